esc_ping_timer: RTL and testbench
=================================

// Module: esc_ping_timer
// PURPOSE
//  Upstream controller for a bank of escalation sender/receiver pairs. Periodically
//  pings one escalation channel at a time (round-robin) via its ping_en input and
//  checks that the channel answers with ping_ok within a timeout.
//  Missed pings and any channel integrity failure are reported to the alert/escalation
//  classification logic.
// PARAMETERS
//  N_ESC   4   number of escalation channels pinged (>=2)
//  CNT_W   16  width of period/timeout counter and config inputs
//  IDX_W   $clog2(N_ESC)  width of channel index (localparam)
// PORTS
//  clk_i             in   1      clock
//  rst_ni            in   1      asynchronous active-low reset
//  en_i              in   1      enable ping mechanism (level)
//  period_i          in   CNT_W  cycles spent in WAIT between pings (quasi-static)
//  timeout_i         in   CNT_W  max cycles a ping may stay outstanding (quasi-static)
//  esc_ping_ok_i     in   N_ESC  per-channel ping_ok pulse from the escalation senders
//  esc_integ_fail_i  in   N_ESC  per-channel integ_fail from the escalation senders
//  esc_ping_en_o     out  N_ESC  per-channel ping request, one-hot or zero
//  ping_fail_o       out  1      ping timeout on channel fail_idx_o
//  fail_idx_o        out  IDX_W  channel that timed out
//  integ_fail_o      out  1      registered OR of esc_integ_fail_i
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt=0, sel=0.
//  FSM states IDLE / WAIT / PING. All outputs are registered.
//  - IDLE: cnt=0, esc_ping_en_o=0. en_i=1 -> WAIT.
//  - WAIT: cnt++ each cycle. cnt==max(period_i,1)-1 -> PING with cnt:=0;
//    esc_ping_en_o[sel] rises on that edge.
//  - PING: esc_ping_en_o=onehot(sel), held until the ping closes. cnt++ each cycle.
//    * esc_ping_ok_i[sel]=1 -> ping closes OK.
//    * else cnt==max(timeout_i,1)-1 -> ping closes FAIL: ping_fail_o pulses 1 cycle,
//      fail_idx_o:=sel.
//    * ok and timeout in the same cycle -> OK wins, no fail.
//    * On either close: ping_en drops on the same edge, sel:=(sel==N_ESC-1)?0:sel+1,
//      cnt:=0, -> WAIT.
//  - esc_ping_ok_i bits of non-selected channels, and all bits outside PING, are ignored.
//  - en_i=0 in any state -> IDLE on next edge. ping_en drops, cnt clears, sel is kept,
//    and no fail is raised for an aborted ping.
//  - integ_fail_o = |esc_integ_fail_i, one-cycle latency, independent of FSM and en_i.
//  - Counter never wraps: it is always cleared at its terminal compare before overflow.
//  - Minimum ping-to-ping spacing: period 1, timeout 1 -> ping_en high 1 cycle, then low
//    1 cycle.
// CONFIGURATION
//  ESC_PING_STICKY_EN defined:
//    - ping_fail_o is sticky: set on the first timeout, cleared only by en_i=0 or reset.
//    - fail_idx_o freezes at the first failing channel.
//    - Pinging continues normally.
//  ESC_PING_STICKY_EN undefined:
//    - ping_fail_o is a 1-cycle pulse per timeout.
//    - fail_idx_o updates on every timeout.
// TESTING
//  1. Reset, then en_i=1, period=3, timeout=5, each ok returned 2 cycles after ping_en
//     rises -> ping_en walks 0001,0010,0100,1000,0001; ping_fail_o stays 0.
//  2. Channel 2 never answers, timeout=5 -> ping_en[2] high exactly 5 cycles, then
//     ping_fail_o=1 for 1 cycle with fail_idx_o=2, next ping targets channel 3.
//  3. ok on the selected channel in the same cycle the timeout is reached -> no ping_fail_o,
//     sel advances.
//  4. ok on a non-selected channel during PING -> ignored, ping still times out.
//  5. en_i dropped mid-PING -> ping_en=0 next cycle, no fail. Re-enable -> the same channel
//     is pinged after period cycles.
//  6. esc_integ_fail_i=4'b0100 for 1 cycle -> integ_fail_o=1 one cycle later for one cycle.
//     With ESC_PING_STICKY_EN, test 2 keeps ping_fail_o=1 until en_i=0.

Source files
------------

// File: rtl/esc_ping_timer.sv
// rtl/esc_ping_timer.sv - round-robin escalation ping timer with ping timeout and integrity reporting
// Optional feature macro: ESC_PING_STICKY_EN (sticky ping_fail_o, fail_idx_o frozen at first failure)
module esc_ping_timer #(
    parameter int N_ESC = 4,
    parameter int CNT_W = 16,
    localparam int IDX_W = $clog2(N_ESC)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic [N_ESC-1:0] esc_ping_ok_i,
    input  logic [N_ESC-1:0] esc_integ_fail_i,
    output logic [N_ESC-1:0] esc_ping_en_o,
    output logic             ping_fail_o,
    output logic [IDX_W-1:0] fail_idx_o,
    output logic             integ_fail_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PING = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] sel;
    logic [CNT_W-1:0] period_tc;
    logic [CNT_W-1:0] timeout_tc;
    logic             ok_sel;
    logic [IDX_W-1:0] sel_next;
    logic [N_ESC-1:0] sel_onehot;

    // A zero period/timeout behaves as one cycle so the terminal compare is always reachable.
    always_comb begin
        period_tc  = (period_i == '0) ? '0 : period_i - 1'b1;
        timeout_tc = (timeout_i == '0) ? '0 : timeout_i - 1'b1;
        ok_sel     = esc_ping_ok_i[sel];
        sel_next   = (sel == IDX_W'(N_ESC - 1)) ? '0 : sel + 1'b1;
        sel_onehot = {{(N_ESC-1){1'b0}}, 1'b1} << sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            sel           <= '0;
            esc_ping_en_o <= '0;
            ping_fail_o   <= 1'b0;
            fail_idx_o    <= '0;
            integ_fail_o  <= 1'b0;
        end else begin
            integ_fail_o <= |esc_integ_fail_i;
`ifndef ESC_PING_STICKY_EN
            ping_fail_o  <= 1'b0;
`endif
            if (!en_i) begin
                // Aborted pings are not failures; sel is retained so the same channel is retried.
                state         <= IDLE;
                cnt           <= '0;
                esc_ping_en_o <= '0;
                ping_fail_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                    WAIT: begin
                        if (cnt == period_tc) begin
                            state         <= PING;
                            cnt           <= '0;
                            esc_ping_en_o <= sel_onehot;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PING: begin
                        if (ok_sel || (cnt == timeout_tc)) begin
                            if (!ok_sel) begin
`ifdef ESC_PING_STICKY_EN
                                if (!ping_fail_o) begin
                                    fail_idx_o <= sel;
                                end
`else
                                fail_idx_o <= sel;
`endif
                                ping_fail_o <= 1'b1;
                            end
                            state         <= WAIT;
                            cnt           <= '0;
                            sel           <= sel_next;
                            esc_ping_en_o <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        cnt           <= '0;
                        esc_ping_en_o <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_esc_ping_timer.sv
// tb/tb_esc_ping_timer.sv - self-checking bench for esc_ping_timer (deadline-based model plus directed literals)
module tb_esc_ping_timer;

`ifdef ESC_PING_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] period = 16'd3;
    logic [15:0] timeout = 16'd5;
    logic [3:0]  integ = 4'b0;
    logic [3:0]  resp_ok = 4'b0;
    logic [3:0]  ping_ok;
    logic [3:0]  esc_ping_en;
    logic        ping_fail;
    logic [1:0]  fail_idx;
    logic        integ_fail;

    int n_checks = 0;
    int n_fail = 0;

    int         resp_delay = 2;
    logic [3:0] resp_mask = 4'hF;
    bit         resp_wrong = 1'b0;
    int         age = 0;

    assign ping_ok = resp_ok;

    esc_ping_timer #(.N_ESC(4), .CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .en_i             (en),
        .period_i         (period),
        .timeout_i        (timeout),
        .esc_ping_ok_i    (ping_ok),
        .esc_integ_fail_i (integ),
        .esc_ping_en_o    (esc_ping_en),
        .ping_fail_o      (ping_fail),
        .fail_idx_o       (fail_idx),
        .integ_fail_o     (integ_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks ping start/close times as absolute edge deadlines.
    int         now = 0;
    bit         m_idle = 1'b1;
    bit         m_ping = 1'b0;
    int         m_sel = 0;
    int         due = 0;
    int         deadline = 0;
    logic [3:0] e_en = 4'b0;
    logic       e_fail = 1'b0;
    logic [1:0] e_idx = 2'b0;
    logic       e_integ = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now = 0; m_idle = 1'b1; m_ping = 1'b0; m_sel = 0;
            e_en = 4'b0; e_fail = 1'b0; e_idx = 2'b0; e_integ = 1'b0;
        end else begin
            now++;
            e_integ = |integ;
            if (!en) begin
                m_idle = 1'b1; m_ping = 1'b0; e_en = 4'b0; e_fail = 1'b0;
            end else begin
                if (!STICKY) e_fail = 1'b0;
                if (m_idle) begin
                    m_idle = 1'b0;
                    due = now + ((period == 0) ? 1 : int'(period));
                end else if (m_ping) begin
                    if (ping_ok[m_sel] || now == deadline) begin
                        if (!ping_ok[m_sel]) begin
                            if (!(STICKY && e_fail)) e_idx = 2'(m_sel);
                            e_fail = 1'b1;
                        end
                        m_ping = 1'b0;
                        e_en = 4'b0;
                        m_sel = (m_sel + 1) % 4;
                        due = now + ((period == 0) ? 1 : int'(period));
                    end
                end else if (now == due) begin
                    m_ping = 1'b1;
                    deadline = now + ((timeout == 0) ? 1 : int'(timeout));
                    e_en = 4'(1 << m_sel);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_ping_en", 32'(esc_ping_en), 32'(e_en));
            check("model_ping_fail", 32'(ping_fail), 32'(e_fail));
            check("model_fail_idx", 32'(fail_idx), 32'(e_idx));
            check("model_integ_fail", 32'(integ_fail), 32'(e_integ));
        end
    end

    // Responder: answers a ping resp_delay cycles after ping_en is first seen high.
    always @(negedge clk) begin
        if (!rst_n || esc_ping_en == 4'b0) begin
            age = 0;
            resp_ok = 4'b0;
        end else begin
            age++;
            if (age == resp_delay)
                resp_ok = resp_wrong ? ~esc_ping_en : (esc_ping_en & resp_mask);
            else
                resp_ok = 4'b0;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // mask == 0 waits for any ping.
    task automatic wait_ping(input logic [3:0] mask, input int budget, input string name, output int n);
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            hit = (mask == 4'b0) ? (esc_ping_en != 4'b0) : (esc_ping_en == mask);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: ping_en %0h never reached %0h within %0d cycles", name, esc_ping_en, mask, budget);
        end
    endtask

    initial begin
        int         n;
        logic [3:0] prev;
        logic [3:0] rot;

        tick(3);
        check("reset_ping_en", 32'(esc_ping_en), 32'h0);
        check("reset_ping_fail", 32'(ping_fail), 32'h0);
        check("reset_fail_idx", 32'(fail_idx), 32'h0);
        check("reset_integ_fail", 32'(integ_fail), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Round-robin walk with prompt answers.
        en = 1'b1;
        wait_ping(4'b0001, 20, "walk_ch0", n);
        check("walk_first_latency", 32'(n), 32'd4);
        wait_ping(4'b0010, 20, "walk_ch1", n);
        check("walk_spacing_ch1", 32'(n), 32'd5);
        wait_ping(4'b0100, 20, "walk_ch2", n);
        check("walk_spacing_ch2", 32'(n), 32'd5);
        wait_ping(4'b1000, 20, "walk_ch3", n);
        check("walk_spacing_ch3", 32'(n), 32'd5);
        wait_ping(4'b0001, 20, "walk_wrap_ch0", n);
        check("walk_spacing_wrap", 32'(n), 32'd5);

        // Channel 2 never answers.
        resp_mask = 4'b1011;
        wait_ping(4'b0100, 40, "silent_ch2", n);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("silent_ping_held", 32'(esc_ping_en), 32'h4);
        end
        tick(1);
        check("silent_ping_dropped", 32'(esc_ping_en), 32'h0);
        check("silent_fail_pulse", 32'(ping_fail), 32'h1);
        check("silent_fail_idx", 32'(fail_idx), 32'h2);
        tick(1);
        check("silent_fail_after", 32'(ping_fail), STICKY ? 32'h1 : 32'h0);
        resp_mask = 4'hF;
        wait_ping(4'b1000, 20, "after_fail_ch3", n);
        check("after_fail_latency", 32'(n), 32'd2);

        // Answer lands in the timeout cycle: OK wins.
        resp_delay = 5;
        tick(4);
        check("race_ping_held", 32'(esc_ping_en), 32'h8);
        tick(1);
        check("race_ping_closed", 32'(esc_ping_en), 32'h0);
        check("race_no_new_fail", 32'(ping_fail), STICKY ? 32'h1 : 32'h0);
        wait_ping(4'b0001, 20, "race_next_ch0", n);
        check("race_next_latency", 32'(n), 32'd3);

        // Answers only on non-selected channels are ignored.
        resp_wrong = 1'b1;
        resp_delay = 2;
        tick(4);
        check("wrong_ping_held", 32'(esc_ping_en), 32'h1);
        tick(1);
        check("wrong_ping_dropped", 32'(esc_ping_en), 32'h0);
        check("wrong_fail", 32'(ping_fail), 32'h1);
        check("wrong_fail_idx", 32'(fail_idx), STICKY ? 32'h2 : 32'h0);
        resp_wrong = 1'b0;

        // Abort mid-ping, then retry the same channel.
        resp_delay = 0;
        wait_ping(4'b0010, 20, "abort_ch1", n);
        tick(1);
        en = 1'b0;
        tick(1);
        check("abort_ping_dropped", 32'(esc_ping_en), 32'h0);
        check("abort_no_fail", 32'(ping_fail), 32'h0);
        tick(2);
        en = 1'b1;
        wait_ping(4'b0010, 20, "abort_retry_ch1", n);
        check("abort_retry_latency", 32'(n), 32'd4);
        resp_delay = 2;

        // Integrity failure forwarding.
        tick(1);
        integ = 4'b0100;
        tick(1);
        check("integ_set", 32'(integ_fail), 32'h1);
        integ = 4'b0000;
        tick(1);
        check("integ_clear", 32'(integ_fail), 32'h0);

        // Minimum spacing: period 0 (treated as 1), timeout 1, answered in the first cycle.
        tick(6);
        en = 1'b0;
        tick(2);
        period = 16'd0;
        timeout = 16'd1;
        resp_delay = 1;
        en = 1'b1;
        wait_ping(4'b0, 20, "min_first", n);
        prev = esc_ping_en;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("min_gap", 32'(esc_ping_en), 32'h0);
            tick(1);
            rot = {prev[2:0], prev[3]};
            check("min_next", 32'(esc_ping_en), 32'(rot));
            prev = rot;
        end

        // Timeout 0 with silent channels: back-to-back failures.
        en = 1'b0;
        tick(2);
        timeout = 16'd0;
        resp_mask = 4'b0;
        en = 1'b1;
        tick(20);

        en = 1'b0;
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
